wash_sequencer: RTL and testbench



---
 rtl/wash_if.sv | 30 +++
 rtl/wash_sequencer.sv | 120 ++++++++++++
 tb/tb_wash_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wash_if.sv
// Panel/control bundle for wash_sequencer. Build with WASH_ABORT_EN to add the abort input.
interface wash_if #(
  parameter int MAX_REPEAT = 4
);
  localparam int RW = $clog2(MAX_REPEAT + 1);

  logic [1:0]    clk_freq;
  logic          coin_in;
  logic [RW-1:0] wash_reps;
  logic          timer_pause;
`ifdef WASH_ABORT_EN
  logic          abort;
`endif
  logic          wash_done;
  logic          busy;
  logic [2:0]    phase;
  logic [RW-1:0] reps_left;

`ifdef WASH_ABORT_EN
  modport master (output clk_freq, coin_in, wash_reps, timer_pause, abort,
                  input  wash_done, busy, phase, reps_left);
  modport slave  (input  clk_freq, coin_in, wash_reps, timer_pause, abort,
                  output wash_done, busy, phase, reps_left);
`else
  modport master (output clk_freq, coin_in, wash_reps, timer_pause,
                  input  wash_done, busy, phase, reps_left);
  modport slave  (input  clk_freq, coin_in, wash_reps, timer_pause,
                  output wash_done, busy, phase, reps_left);
`endif
endinterface

// File: rtl/wash_sequencer.sv
// Washing-machine phase FSM with per-phase second timer and programmable wash/rinse repeats.
// Optional WASH_ABORT_EN: abort in FILL/WASH/RINSE drains straight into a full SPIN.
module wash_sequencer #(
  parameter int TICK_DIV   = 1000000,
  parameter int FILL_SEC   = 120,
  parameter int WASH_SEC   = 300,
  parameter int RINSE_SEC  = 120,
  parameter int SPIN_SEC   = 60,
  parameter int MAX_REPEAT = 4,
  parameter int TIME_W     = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  wash_if.slave bus
);
  localparam int RW = $clog2(MAX_REPEAT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FILL = 3'd1, S_WASH = 3'd2, S_RINSE = 3'd3, S_SPIN = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [1:0]          freq_q;
  logic [RW-1:0]       reps_q, reps_in;
  logic [TIME_W-1:0]   cyc_q, sec_q, cps_m1, sec_tgt;
  logic                expire, hold, abort_req, start;

  assign start  = (state == S_IDLE) && bus.coin_in;
  assign cps_m1 = (TIME_W'(TICK_DIV) << freq_q) - TIME_W'(1);
  assign hold   = (state == S_SPIN) && bus.timer_pause;

`ifdef WASH_ABORT_EN
  assign abort_req = bus.abort &&
                     (state == S_FILL || state == S_WASH || state == S_RINSE);
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    sec_tgt = '0;
    case (state)
      S_FILL:  sec_tgt = TIME_W'(FILL_SEC);
      S_WASH:  sec_tgt = TIME_W'(WASH_SEC);
      S_RINSE: sec_tgt = TIME_W'(RINSE_SEC);
      S_SPIN:  sec_tgt = TIME_W'(SPIN_SEC);
      default: sec_tgt = '0;
    endcase
  end

  // A zero-second phase expires on its first cycle, so it still lasts one cycle.
  assign expire = (sec_tgt == '0) ||
                  ((sec_q + TIME_W'(1) == sec_tgt) && (cyc_q == cps_m1));

  always_comb begin
    reps_in = bus.wash_reps;
    if (bus.wash_reps == '0)                   reps_in = RW'(1);
    else if (bus.wash_reps > RW'(MAX_REPEAT))  reps_in = RW'(MAX_REPEAT);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.coin_in) state_nx = S_FILL;
      S_FILL:  if (abort_req) state_nx = S_SPIN;
               else if (expire) state_nx = S_WASH;
      S_WASH:  if (abort_req) state_nx = S_SPIN;
               else if (expire) state_nx = S_RINSE;
      S_RINSE: if (abort_req) state_nx = S_SPIN;
               else if (expire) state_nx = (reps_q > RW'(1)) ? S_WASH : S_SPIN;
      S_SPIN:  if (expire && !hold) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from registered state
  always_comb begin
    bus.wash_done = (state == S_IDLE);
    bus.busy      = (state != S_IDLE);
    bus.phase     = state;
    bus.reps_left = reps_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q <= '0;
      reps_q <= '0;
    end else if (start) begin
      freq_q <= bus.clk_freq;
      reps_q <= reps_in;
    end else if (abort_req) begin
      reps_q <= '0;
    end else if (state == S_RINSE && expire) begin
      reps_q <= (reps_q > RW'(1)) ? reps_q - RW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      sec_q <= '0;
    end else if (state_nx != state) begin
      cyc_q <= '0;
      sec_q <= '0;
    end else if (state != S_IDLE && !hold) begin
      if (cyc_q == cps_m1) begin
        cyc_q <= '0;
        sec_q <= sec_q + TIME_W'(1);
      end else begin
        cyc_q <= cyc_q + TIME_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_wash_sequencer.sv
// Randomized bench for wash_sequencer: expected per-cycle phase/reps trace built from phase durations.
module tb_wash_sequencer;
  localparam int TICK_DIV = 2, FILL_SEC = 1, WASH_SEC = 2, RINSE_SEC = 1, SPIN_SEC = 1;
  localparam int MAX_REPEAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wash_if #(.MAX_REPEAT(MAX_REPEAT)) bus ();

  wash_sequencer #(
    .TICK_DIV(TICK_DIV), .FILL_SEC(FILL_SEC), .WASH_SEC(WASH_SEC),
    .RINSE_SEC(RINSE_SEC), .SPIN_SEC(SPIN_SEC), .MAX_REPEAT(MAX_REPEAT), .TIME_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int q_ph[$], q_rp[$], q_pz[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".phase"}, 32'(bus.phase), 0);
    chk({tag, ".done"},  32'(bus.wash_done), 1);
    chk({tag, ".busy"},  32'(bus.busy), 0);
    chk({tag, ".reps"},  32'(bus.reps_left), 0);
  endtask

  function automatic int seg_len(int sec, int cps);
    return (sec == 0) ? 1 : sec * cps;
  endfunction

  // Pause is don't-care outside SPIN, so it is randomized there.
  function automatic void push_seg(int ph, int rp, int n);
    for (int i = 0; i < n; i++) begin
      q_ph.push_back(ph); q_rp.push_back(rp); q_pz.push_back(int'($urandom_range(0, 1)));
    end
  endfunction

  // f: clk_freq at coin, reps_in: raw wash_reps, k/l: pause start offset and length within SPIN
  task automatic run_seq(input int f, input int reps_in, input int k, input int l);
    int r, cps;
    r   = (reps_in == 0) ? 1 : ((reps_in > MAX_REPEAT) ? MAX_REPEAT : reps_in);
    cps = TICK_DIV << f;
    q_ph.delete(); q_rp.delete(); q_pz.delete();
    push_seg(1, r, seg_len(FILL_SEC, cps));
    for (int i = r; i >= 1; i--) begin
      push_seg(2, i, seg_len(WASH_SEC, cps));
      push_seg(3, i, seg_len(RINSE_SEC, cps));
    end
    for (int i = 0; i < seg_len(SPIN_SEC, cps) + l; i++) begin
      q_ph.push_back(4); q_rp.push_back(0); q_pz.push_back((i >= k && i < k + l) ? 1 : 0);
    end

    @(posedge clk); #1;
    bus.coin_in = 1'b1; bus.clk_freq = 2'(f); bus.wash_reps = 3'(reps_in);
    bus.timer_pause = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_idle("pre_coin");
    foreach (q_ph[c]) begin
      @(posedge clk); #1;
      bus.coin_in     = 1'($urandom_range(0, 1));
      bus.clk_freq    = 2'($urandom_range(0, 3));
      bus.wash_reps   = 3'($urandom_range(0, 7));
      bus.timer_pause = 1'(q_pz[c]);
      @(negedge clk);
      chk($sformatf("phase[f%0d r%0d c%0d]", f, reps_in, c), 32'(bus.phase), 32'(q_ph[c]));
      chk($sformatf("reps[f%0d r%0d c%0d]", f, reps_in, c), 32'(bus.reps_left), 32'(q_rp[c]));
      chk($sformatf("busy[c%0d]", c), 32'(bus.busy), 1);
      chk($sformatf("done[c%0d]", c), 32'(bus.wash_done), 0);
    end
    @(posedge clk); #1;
    bus.coin_in = 1'b0; bus.timer_pause = 1'b0;
    @(negedge clk);
    check_idle("post_run");
  endtask

  initial begin
    int f;
    bus.coin_in = 1'b0; bus.clk_freq = 2'd0; bus.wash_reps = 3'd0; bus.timer_pause = 1'b0;
`ifdef WASH_ABORT_EN
    bus.abort = 1'b0;
`endif
    #2;
    check_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_seq(0, 1, 0, 0);   // 2,4,2,2 cycles
    run_seq(0, 3, 0, 0);   // 22 busy cycles
    run_seq(0, 0, 0, 0);   // zero treated as one
    run_seq(0, 7, 0, 0);   // saturates to MAX_REPEAT
    run_seq(2, 1, 0, 0);   // FILL of 8 cycles, clk_freq wiggled while busy
    run_seq(0, 1, 1, 5);   // SPIN of 2+5 cycles
    run_seq(0, 2, 1, 3);   // pause covering the expiry cycle

    // Asynchronous reset in WASH, then a clean restart
    @(posedge clk); #1;
    bus.coin_in = 1'b1; bus.clk_freq = 2'd0; bus.wash_reps = 3'd2; bus.timer_pause = 1'b0;
    @(posedge clk); #1 bus.coin_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst.phase", 32'(bus.phase), 2);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk) rst_n = 1'b1;
    run_seq(1, 2, 0, 0);

`ifdef WASH_ABORT_EN
    @(posedge clk); #1;
    bus.coin_in = 1'b1; bus.clk_freq = 2'd0; bus.wash_reps = 3'd3; bus.timer_pause = 1'b0;
    @(posedge clk); #1 bus.coin_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.abort = 1'b1;
    @(negedge clk) chk("abort.pre", 32'(bus.phase), 2);
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort.phase", 32'(bus.phase), 4);
    chk("abort.reps", 32'(bus.reps_left), 0);
    @(posedge clk); #1;
    @(negedge clk) chk("abort.spin2", 32'(bus.phase), 4);
    @(posedge clk); #1;
    @(negedge clk) check_idle("abort.end");
`endif

    for (int n = 0; n < 25; n++) begin
      f = int'($urandom_range(0, 3));
      run_seq(f, int'($urandom_range(0, 7)),
              int'($urandom_range(0, (TICK_DIV << f) - 1)), int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
